// File: rtl/imgburst_reader.sv
// Bursting Wishbone frame-buffer reader: fetches lines in bursts into a FWFT FIFO, streams words out.
// Build option OPT_VFLIP_EN: read the frame bottom-up, start address found by a shift-add multiply.
module imgburst_reader #(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int LGFIFO  = 10,
  parameter int LGBURST = 5,
  parameter int LW      = 12
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_newframe,
  input  logic [AW-1:0] i_baseaddr,
  input  logic [AW-1:0] i_linestride,
  input  logic [LW-1:0] i_linewords,
  input  logic [LW-1:0] i_nlines,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic [AW-1:0] o_wb_addr,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_word,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_err,
  output logic          o_busy
);
  localparam int BW         = LGBURST + 1;
  localparam int FW         = LGFIFO + 1;
  localparam int FIFO_DEPTH = 1 << LGFIFO;

`ifdef OPT_VFLIP_EN
  localparam int CW = $clog2(LW + 1);
  typedef enum logic [2:0] {IDLE, ROOM, BURST, DRAIN, DONE, MULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ROOM, BURST, DRAIN, DONE} state_t;
`endif

  state_t state, next_state;

  logic [AW-1:0] stride_r, line_addr, next_line;
  logic [LW-1:0] linewords_r, nlines_r, word_idx, line_idx;
  logic [LW-1:0] words_left, push_pos;
  logic [BW-1:0] burst_len, req_cnt, ack_cnt, room_blen;
  logic [FW-1:0] fill, free_words;
  logic          room_ok, accept, ack_in, burst_done, last_req, line_end, last_line;
  logic          push, pop;

  logic [DW+1:0]     mem [FIFO_DEPTH];
  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [DW+1:0]     rd_data;

`ifdef OPT_VFLIP_EN
  logic [LW-1:0] mult_a;
  logic [AW-1:0] mult_b, mult_acc, mult_sum;
  logic [CW-1:0] mult_cnt;
  assign mult_sum  = mult_acc + (mult_a[0] ? mult_b : '0);
  assign next_line = line_addr - stride_r;
`else
  assign next_line = line_addr + stride_r;
`endif

  assign words_left = linewords_r - word_idx;
  assign room_blen  = (words_left > LW'(1 << LGBURST)) ? BW'(1 << LGBURST) : words_left[BW-1:0];
  assign free_words = FW'(FIFO_DEPTH) - fill;
  assign room_ok    = free_words >= FW'(room_blen);
  assign accept     = o_wb_stb && !i_wb_stall;
  assign ack_in     = o_wb_cyc && i_wb_ack && !i_wb_err;
  assign last_req   = (req_cnt + BW'(1)) == burst_len;
  assign burst_done = ack_in && ((ack_cnt + BW'(1)) == burst_len);
  assign line_end   = (word_idx + LW'(burst_len)) == linewords_r;
  assign last_line  = (line_idx + LW'(1)) == nlines_r;
  assign push_pos   = word_idx + LW'(ack_cnt);

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else            state <= next_state;

  // New frame overrides everything, a bus error comes next, then normal sequencing.
  always_comb begin
    next_state = state;
    if (i_newframe) begin
      if (i_linewords == '0 || i_nlines == '0) next_state = DONE;
`ifdef OPT_VFLIP_EN
      else                                     next_state = MULT;
`else
      else                                     next_state = ROOM;
`endif
    end else if (o_wb_cyc && i_wb_err) begin
      next_state = DONE;
    end else begin
      case (state)
        ROOM:  if (room_ok) next_state = BURST;
        BURST, DRAIN: begin
          if (burst_done)                           next_state = (line_end && last_line) ? DONE : ROOM;
          else if (state == BURST && accept && last_req) next_state = DRAIN;
        end
`ifdef OPT_VFLIP_EN
        MULT:  if (mult_cnt == CW'(LW - 1)) next_state = ROOM;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_addr   <= '0;
      o_err       <= 1'b0;
      stride_r    <= '0;
      linewords_r <= '0;
      nlines_r    <= '0;
      line_addr   <= '0;
      word_idx    <= '0;
      line_idx    <= '0;
      burst_len   <= '0;
      req_cnt     <= '0;
      ack_cnt     <= '0;
`ifdef OPT_VFLIP_EN
      mult_a      <= '0;
      mult_b      <= '0;
      mult_acc    <= '0;
      mult_cnt    <= '0;
`endif
    end else if (i_newframe) begin
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_addr   <= i_baseaddr;
      o_err       <= 1'b0;
      stride_r    <= i_linestride;
      linewords_r <= i_linewords;
      nlines_r    <= i_nlines;
      line_addr   <= i_baseaddr;
      word_idx    <= '0;
      line_idx    <= '0;
      req_cnt     <= '0;
      ack_cnt     <= '0;
`ifdef OPT_VFLIP_EN
      mult_a      <= i_nlines - LW'(1);
      mult_b      <= i_linestride;
      mult_acc    <= '0;
      mult_cnt    <= '0;
`endif
    end else if (o_wb_cyc && i_wb_err) begin
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_err    <= 1'b1;
    end else begin
      case (state)
        ROOM: if (room_ok) begin
          o_wb_cyc  <= 1'b1;
          o_wb_stb  <= 1'b1;
          burst_len <= room_blen;
          req_cnt   <= '0;
          ack_cnt   <= '0;
        end
        BURST, DRAIN: begin
          if (accept) begin
            o_wb_addr <= o_wb_addr + AW'(1);
            req_cnt   <= req_cnt + BW'(1);
            if (last_req) o_wb_stb <= 1'b0;
          end
          if (ack_in) ack_cnt <= ack_cnt + BW'(1);
          // Final ack closes the cycle; the line start only moves when a whole line is done.
          if (burst_done) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            if (!line_end) begin
              word_idx <= word_idx + LW'(burst_len);
            end else begin
              word_idx <= '0;
              if (!last_line) begin
                line_idx  <= line_idx + LW'(1);
                line_addr <= next_line;
                o_wb_addr <= next_line;
              end
            end
          end
        end
`ifdef OPT_VFLIP_EN
        MULT: begin
          mult_acc <= mult_sum;
          mult_a   <= mult_a >> 1;
          mult_b   <= mult_b << 1;
          mult_cnt <= mult_cnt + CW'(1);
          if (mult_cnt == CW'(LW - 1)) begin
            line_addr <= line_addr + mult_sum;
            o_wb_addr <= line_addr + mult_sum;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign push = ack_in && !i_newframe;
  assign pop  = o_valid && i_ready;

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= {(line_idx == '0) && (push_pos == '0),
                              push_pos == (linewords_r - LW'(1)), i_wb_data};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (i_newframe) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LGFIFO'(1);
      if (pop)  rd_ptr <= rd_ptr + LGFIFO'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: ;
      endcase
    end
  end

  // Head entry is read combinationally (first-word fall-through); gated so idle outputs are zero.
  assign rd_data = mem[rd_ptr];
  assign o_valid = fill != '0;
  assign o_word  = o_valid ? rd_data[DW-1:0] : '0;
  assign o_sof   = o_valid && rd_data[DW+1];
  assign o_eol   = o_valid && rd_data[DW];
  assign o_busy  = (state != IDLE && state != DONE) || o_valid;

endmodule

// File: tb/tb_imgburst_reader.sv
// Randomised bench for imgburst_reader: a frame-level model predicts bus addresses and stream words.
module tb_imgburst_reader;
  localparam int AW = 24, DW = 32, LGFIFO = 6, LGBURST = 5, LW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_newframe, i_wb_ack, i_wb_stall, i_wb_err, i_ready;
  logic [AW-1:0] i_baseaddr, i_linestride, o_wb_addr;
  logic [LW-1:0] i_linewords, i_nlines;
  logic [DW-1:0] i_wb_data, o_word;
  logic          o_wb_cyc, o_wb_stb, o_valid, o_sof, o_eol, o_err, o_busy;

  always #5 clk = ~clk;

  imgburst_reader #(.AW(AW), .DW(DW), .LGFIFO(LGFIFO), .LGBURST(LGBURST), .LW(LW)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_newframe(i_newframe),
    .i_baseaddr(i_baseaddr), .i_linestride(i_linestride),
    .i_linewords(i_linewords), .i_nlines(i_nlines),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_word(o_word),
    .o_sof(o_sof), .o_eol(o_eol), .o_err(o_err), .o_busy(o_busy)
  );

  int checks = 0, errors = 0;
  logic [AW-1:0] exp_addr[$], req_log[$], pend_addr[$];
  logic [DW+1:0] exp_stream[$], stream_log[$];
  int            burst_log[$], pend_idx[$];
  int            req_idx = 0, acks_driven = 0, err_cur = 0;
  int            stall_pct = 0, ack_pct = 100, ready_pct = 100;
  logic [AW-1:0] f_base, f_stride;
  int            f_lw, f_nl, f_err;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame model: every word of every line in fetch order, truncated before an injected bus error.
  task automatic buildModel();
    logic [AW-1:0] a, ls;
    int n;
    n = 0;
    exp_addr.delete();
    exp_stream.delete();
    for (int l = 0; l < f_nl; l++) begin
`ifdef OPT_VFLIP_EN
      ls = f_base + AW'(f_nl - 1 - l) * f_stride;
`else
      ls = f_base + AW'(l) * f_stride;
`endif
      for (int w = 0; w < f_lw; w++) begin
        a = ls + AW'(w);
        n++;
        exp_addr.push_back(a);
        if (f_err == 0 || n < f_err)
          exp_stream.push_back({mem_word(a), (l == 0 && w == 0), (w == f_lw - 1)});
      end
    end
  endtask

  task automatic acceptRequest();
    if (o_wb_stb && !i_wb_stall) begin
      req_idx++;
      pend_addr.push_back(o_wb_addr);
      pend_idx.push_back(req_idx);
    end
  endtask

  // One cycle of stimulus: optional new-frame pulse, a pipelined Wishbone slave and the consumer.
  task automatic applyStimulus(input bit nf);
    bit zero_lat;
    @(negedge clk);
    i_newframe = nf;
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    if (nf) begin
      i_baseaddr   = f_base;
      i_linestride = f_stride;
      i_linewords  = LW'(f_lw);
      i_nlines     = LW'(f_nl);
      buildModel();
      req_log.delete();
      stream_log.delete();
      burst_log.delete();
      req_idx     = 0;
      acks_driven = 0;
      err_cur     = f_err;
    end
    i_ready = nf ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
    if (!o_wb_cyc) begin
      i_wb_stall = ($urandom_range(0, 99) < stall_pct);
      if (pend_addr.size() > 0) begin
        i_wb_ack  = 1'b1;
        i_wb_data = 32'hDEADBEEF;
        pend_addr.delete();
        pend_idx.delete();
      end
    end else begin
      i_wb_stall = nf || ($urandom_range(0, 99) < stall_pct);
      zero_lat = 1'($urandom_range(0, 1));
      if (zero_lat) acceptRequest();
      if (!nf && pend_addr.size() > 0 && $urandom_range(0, 99) < ack_pct) begin
        if (pend_idx[0] == err_cur) i_wb_err = 1'b1;
        else begin
          i_wb_ack  = 1'b1;
          i_wb_data = mem_word(pend_addr[0]);
          acks_driven++;
        end
        void'(pend_addr.pop_front());
        void'(pend_idx.pop_front());
      end
      if (!zero_lat) acceptRequest();
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0);
      n++;
    end while (o_busy && n < budget);
    checkOutput({name, "_idle"}, 64'(o_busy), 64'd0);
    repeat (2) applyStimulus(1'b0);
    checkOutput({name, "_words_left"}, 64'(exp_stream.size()), 64'd0);
  endtask

  task automatic setFrame(input logic [AW-1:0] b, input logic [AW-1:0] s, input int lw, input int nl, input int e);
    f_base = b; f_stride = s; f_lw = lw; f_nl = nl; f_err = e;
  endtask

  // Compare process: handshakes are sampled just after the driving edge, before the next posedge.
  initial begin
    int burst_acks;
    bit cyc_prev;
    burst_acks = 0;
    cyc_prev   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
          req_log.push_back(o_wb_addr);
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL req_extra: got request 0x%0h, expected none", o_wb_addr);
          end else checkOutput("req_addr", 64'(o_wb_addr), 64'(exp_addr.pop_front()));
        end
        if (o_valid && i_ready) begin
          stream_log.push_back({o_word, o_sof, o_eol});
          if (exp_stream.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL word_extra: got 0x%0h, expected none", {o_word, o_sof, o_eol});
          end else checkOutput("stream_word", 64'({o_word, o_sof, o_eol}), 64'(exp_stream.pop_front()));
        end
        if (o_wb_cyc && i_wb_ack) burst_acks++;
        if (cyc_prev && !o_wb_cyc) begin
          burst_log.push_back(burst_acks);
          burst_acks = 0;
        end
        cyc_prev = o_wb_cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    reset_n = 1'b0; i_newframe = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_err = 1'b0;
    i_ready = 1'b0; i_wb_data = '0; i_baseaddr = '0; i_linestride = '0; i_linewords = '0; i_nlines = '0;
    setFrame(24'h0, 24'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_cyc",   64'(o_wb_cyc),  64'd0);
    checkOutput("rst_stb",   64'(o_wb_stb),  64'd0);
    checkOutput("rst_addr",  64'(o_wb_addr), 64'd0);
    checkOutput("rst_valid", 64'(o_valid),   64'd0);
    checkOutput("rst_word",  64'(o_word),    64'd0);
    checkOutput("rst_flags", 64'({o_sof, o_eol, o_err}), 64'd0);
    checkOutput("rst_busy",  64'(o_busy),    64'd0);
    reset_n = 1'b1;
    repeat (3) applyStimulus(1'b0);
    checkOutput("idle_busy", 64'(o_busy),   64'd0);
    checkOutput("idle_cyc",  64'(o_wb_cyc), 64'd0);

    $display("[TB] basic frame");
    stall_pct = 0; ack_pct = 100; ready_pct = 100;
    setFrame(24'h100, 24'h10, 8, 2, 0);
    applyStimulus(1'b1);
    waitIdle("basic", 500);
    checkOutput("basic_nreq",   64'(req_log.size()), 64'd16);
    checkOutput("basic_req0",   64'(req_log[0]),  64'h100);
    checkOutput("basic_req8",   64'(req_log[8]),  64'h110);
    checkOutput("basic_req15",  64'(req_log[15]), 64'h117);
    checkOutput("basic_nword",  64'(stream_log.size()), 64'd16);
    checkOutput("basic_sof0",   64'(stream_log[0][1]), 64'd1);
    checkOutput("basic_sof8",   64'(stream_log[8][1]), 64'd0);
    checkOutput("basic_eol7",   64'(stream_log[7][0]), 64'd1);
    checkOutput("basic_eol15",  64'(stream_log[15][0]), 64'd1);
    checkOutput("basic_data3",  64'(stream_log[3][DW+1:2]), 64'h59000103);

    $display("[TB] burst split");
    stall_pct = 30; ack_pct = 60; ready_pct = 80;
    setFrame(24'h2000 + AW'($urandom_range(0, 255)), 24'h100, 70, 2, 0);
    applyStimulus(1'b1);
    waitIdle("split", 5000);
    checkOutput("split_nburst", 64'(burst_log.size()), 64'd6);
    checkOutput("split_b0", 64'(burst_log[0]), 64'd32);
    checkOutput("split_b1", 64'(burst_log[1]), 64'd32);
    checkOutput("split_b2", 64'(burst_log[2]), 64'd6);
    checkOutput("split_b5", 64'(burst_log[5]), 64'd6);

    $display("[TB] backpressure");
    stall_pct = 0; ack_pct = 100; ready_pct = 0;
    setFrame(24'h3000, 24'h40, 32, 4, 0);
    applyStimulus(1'b1);
    repeat (300) applyStimulus(1'b0);
    checkOutput("bp_nreq",  64'(req_log.size()), 64'd64);
    checkOutput("bp_cyc",   64'(o_wb_cyc), 64'd0);
    checkOutput("bp_valid", 64'(o_valid),  64'd1);
    checkOutput("bp_busy",  64'(o_busy),   64'd1);
    ready_pct = 50;
    waitIdle("bp", 5000);
    checkOutput("bp_nword", 64'(stream_log.size()), 64'd128);

    $display("[TB] abort mid-burst");
    stall_pct = 0; ack_pct = 25; ready_pct = 0;
    setFrame(24'h200, 24'h10, 8, 2, 0);
    applyStimulus(1'b1);
    for (int i = 0; i < 400 && acks_driven < 3; i++) applyStimulus(1'b0);
    checkOutput("abort_acks", 64'(acks_driven), 64'd3);
    setFrame(24'h300, 24'h20, 8, 2, 0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("abort_cyc",   64'(o_wb_cyc), 64'd0);
    checkOutput("abort_empty", 64'(o_valid),  64'd0);
    ack_pct = 100; ready_pct = 100;
    waitIdle("abort", 2000);
    checkOutput("abort_req0",  64'(req_log[0]), 64'h300);
    checkOutput("abort_sof",   64'(stream_log[0][1]), 64'd1);
    checkOutput("abort_data0", 64'(stream_log[0][DW+1:2]), 64'h5A000300);

    $display("[TB] bus error");
    setFrame(24'h400, 24'h10, 8, 2, 5);
    applyStimulus(1'b1);
    repeat (30) applyStimulus(1'b0);
    checkOutput("err_flag",  64'(o_err),    64'd1);
    checkOutput("err_cyc",   64'(o_wb_cyc), 64'd0);
    checkOutput("err_busy",  64'(o_busy),   64'd0);
    checkOutput("err_nword", 64'(stream_log.size()), 64'd4);
    checkOutput("err_data3", 64'(stream_log[3][DW+1:2]), 64'h59000403);
    r = req_log.size();
    repeat (20) applyStimulus(1'b0);
    checkOutput("err_noreq", 64'(req_log.size()), 64'(r));
    setFrame(24'h500, 24'h10, 4, 1, 0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("err_clear", 64'(o_err), 64'd0);
    waitIdle("err_next", 1000);

    $display("[TB] degenerate frames");
    setFrame(24'h600, 24'h10, 8, 0, 0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("deg_busy", 64'(o_busy),   64'd0);
    checkOutput("deg_cyc",  64'(o_wb_cyc), 64'd0);
    setFrame(24'h700, 24'h10, 0, 3, 0);
    applyStimulus(1'b1);
    repeat (10) applyStimulus(1'b0);
    checkOutput("deg_nreq", 64'(req_log.size()), 64'd0);
    checkOutput("deg_busy2", 64'(o_busy), 64'd0);

`ifdef OPT_VFLIP_EN
    $display("[TB] vertical flip");
    setFrame(24'h1000, 24'h40, 4, 3, 0);
    applyStimulus(1'b1);
    waitIdle("vflip", 1000);
    checkOutput("vflip_l0", 64'(req_log[0]), 64'h1080);
    checkOutput("vflip_l1", 64'(req_log[4]), 64'h1040);
    checkOutput("vflip_l2", 64'(req_log[8]), 64'h1000);
`endif

    $display("[TB] random frames");
    for (int k = 0; k < 6; k++) begin
      stall_pct = $urandom_range(0, 60);
      ack_pct   = $urandom_range(30, 100);
      ready_pct = $urandom_range(20, 100);
      setFrame(AW'($urandom), AW'($urandom_range(0, 16'hFFFF)),
               $urandom_range(1, 80), $urandom_range(1, 4), 0);
      applyStimulus(1'b1);
      waitIdle("random", 8000);
      checkOutput("random_addr_left", 64'(exp_addr.size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
